hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 34 +++
 rtl/hazard_ctrl_if.sv | 46 ++++
 rtl/hazard_ctrl_hz_decode.sv | 27 ++
 rtl/hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared RISC-V constants for the hazard controller: opcodes, hazard
// classification, controller states and the per-stage decode record.
package hazard_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        HZ_NONE     = 2'd0,
        HZ_LOAD_USE = 2'd1,
        HZ_BR_ALU   = 2'd2,
        HZ_RAW      = 2'd3
    } hz_type_t;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic writes_rd;
        logic is_load;
        logic is_branch;
    } dec_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: stage descriptors and
// kill/freeze requests in, stage enables and stall statistics out.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5
) ();
    import hazard_ctrl_pkg::*;

    // No handshake: each stage descriptor is qualified only by its *_valid bit,
    // and every control output is meaningful in the same cycle it is produced.
    logic              id_valid;
    logic [6:0]        id_opcode;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              ex_valid;
    logic [6:0]        ex_opcode;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_valid;
    logic [6:0]        mem_opcode;
    logic [REG_AW-1:0] mem_rd;
    logic              flush_i;
    logic              ext_stall;

    logic              pc_en;
    logic              fd_en;
    logic              de_bubble;
    logic              fd_flush;
    hz_type_t          hazard_type;
    logic [31:0]       stall_cycles;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2,
        output ex_valid, ex_opcode, ex_rd,
        output mem_valid, mem_opcode, mem_rd,
        output flush_i, ext_stall,
        input  pc_en, fd_en, de_bubble, fd_flush, hazard_type, stall_cycles
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2,
        input  ex_valid, ex_opcode, ex_rd,
        input  mem_valid, mem_opcode, mem_rd,
        input  flush_i, ext_stall,
        output pc_en, fd_en, de_bubble, fd_flush, hazard_type, stall_cycles
    );

endinterface

// File: rtl/hazard_ctrl_hz_decode.sv
// Per-stage decode: which register sources an instruction reads, whether
// it writes a non-zero rd, and whether it is a load or a branch.
module hz_decode
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              valid,
    input  logic [6:0]        opcode,
    input  logic [REG_AW-1:0] rd,
    output dec_t              dec
);

    always_comb begin
        dec           = '0;
        dec.use_rs1   = valid && !(opcode == OPC_JAL || opcode == OPC_LUI ||
                                   opcode == OPC_AUIPC);
        dec.use_rs2   = valid && (opcode == OPC_BRANCH || opcode == OPC_STORE ||
                                  opcode == OPC_OP);
        // x0 is hardwired, so writing it never creates a dependency
        dec.writes_rd = valid && opcode != OPC_BRANCH && opcode != OPC_STORE &&
                        rd != '0;
        dec.is_load   = valid && opcode == OPC_LOAD;
        dec.is_branch = valid && opcode == OPC_BRANCH;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: detects load-use, branch-after-ALU and
// (without forwarding) RAW hazards and stalls fetch/decode for N cycles.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_DELAY = 2,
    parameter int FWD_EN    = 1,
    parameter int REG_AW    = 5
) (
    input  logic           clk,
    input  logic           nrst,
    hazard_ctrl_if.slave   bus,
    output state_t         dbg_state
);

    localparam int CW = $clog2(MEM_DELAY + 3);

    dec_t id_dec;
    dec_t ex_dec;
    dec_t mem_dec;

    hz_decode #(.REG_AW(REG_AW)) u_id_dec (
        .valid  (bus.id_valid),
        .opcode (bus.id_opcode),
        .rd     ('0),
        .dec    (id_dec)
    );

    hz_decode #(.REG_AW(REG_AW)) u_ex_dec (
        .valid  (bus.ex_valid),
        .opcode (bus.ex_opcode),
        .rd     (bus.ex_rd),
        .dec    (ex_dec)
    );

    hz_decode #(.REG_AW(REG_AW)) u_mem_dec (
        .valid  (bus.mem_valid),
        .opcode (bus.mem_opcode),
        .rd     (bus.mem_rd),
        .dec    (mem_dec)
    );

    logic unused_dec;
    assign unused_dec = ^{id_dec.writes_rd, id_dec.is_load, ex_dec.use_rs1,
                          ex_dec.use_rs2, ex_dec.is_branch, mem_dec.use_rs1,
                          mem_dec.use_rs2, mem_dec.is_load, mem_dec.is_branch};

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = ex_dec.writes_rd &&
                     ((id_dec.use_rs1 && bus.id_rs1 == bus.ex_rd) ||
                      (id_dec.use_rs2 && bus.id_rs2 == bus.ex_rd));
    assign mem_hit = mem_dec.writes_rd &&
                     ((id_dec.use_rs1 && bus.id_rs1 == bus.mem_rd) ||
                      (id_dec.use_rs2 && bus.id_rs2 == bus.mem_rd));

    // Hazard classification, first match wins; det_nm1 is the stall length minus one
    logic          det_hit;
    hz_type_t      det_type;
    logic [CW-1:0] det_nm1;

    always_comb begin
        det_hit  = 1'b0;
        det_type = HZ_NONE;
        det_nm1  = '0;
        if (ex_hit && ex_dec.is_load) begin
            det_hit  = 1'b1;
            det_type = HZ_LOAD_USE;
            det_nm1  = CW'(MEM_DELAY) + CW'(id_dec.is_branch);
        end else if (ex_hit && id_dec.is_branch) begin
            det_hit  = 1'b1;
            det_type = HZ_BR_ALU;
        end else if (FWD_EN == 0 && ex_hit) begin
            det_hit  = 1'b1;
            det_type = HZ_RAW;
            det_nm1  = CW'(1);
        end else if (FWD_EN == 0 && mem_hit) begin
            det_hit  = 1'b1;
            det_type = HZ_RAW;
        end
    end

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    hz_type_t      type_q, type_d;
    logic [31:0]   stall_cycles_q, stall_cycles_d;

    logic          pc_en, fd_en, de_bubble, fd_flush, hz_bubble;
    hz_type_t      hz_out;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        type_d         = type_q;
        stall_cycles_d = stall_cycles_q;
        pc_en          = 1'b0;
        fd_en          = 1'b0;
        de_bubble      = 1'b0;
        fd_flush       = 1'b0;
        hz_bubble      = 1'b0;
        hz_out         = HZ_NONE;

        if (!nrst) begin
            state_d        = ST_RESET;
            cnt_d          = '0;
            type_d         = HZ_NONE;
            stall_cycles_d = '0;
        end else if (state_q == ST_RESET) begin
            state_d = ST_RUN;
        end else if (bus.ext_stall) begin
            // Global freeze: everything holds, only the stall type stays visible
            if (state_q == ST_STALL) hz_out = type_q;
        end else if (bus.flush_i) begin
            pc_en     = 1'b1;
            fd_en     = 1'b1;
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
            state_d   = ST_RUN;
            cnt_d     = '0;
            type_d    = HZ_NONE;
        end else if (state_q == ST_STALL) begin
            de_bubble = 1'b1;
            hz_bubble = 1'b1;
            hz_out    = type_q;
            cnt_d     = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = ST_RUN;
                type_d  = HZ_NONE;
            end
        end else if (det_hit) begin
            de_bubble = 1'b1;
            hz_bubble = 1'b1;
            hz_out    = det_type;
            cnt_d     = det_nm1;
            if (det_nm1 != '0) begin
                state_d = ST_STALL;
                type_d  = det_type;
            end
        end else begin
            pc_en = 1'b1;
            fd_en = 1'b1;
        end

        if (hz_bubble && stall_cycles_q != '1) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        state_q        <= state_d;
        cnt_q          <= cnt_d;
        type_q         <= type_d;
        stall_cycles_q <= stall_cycles_d;
    end

    assign bus.pc_en        = pc_en;
    assign bus.fd_en        = fd_en;
    assign bus.de_bubble    = de_bubble;
    assign bus.fd_flush     = fd_flush;
    assign bus.hazard_type  = hz_out;
    assign bus.stall_cycles = stall_cycles_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with forwarding and one
// without, driven with identical pipeline contents.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam logic [6:0] OP_ADDI = 7'b0010011;
    // Output vector layout: {pc_en, fd_en, de_bubble, fd_flush, hazard_type}
    localparam logic [5:0] V_RUN   = 6'b110000;
    localparam logic [5:0] V_ZERO  = 6'b000000;
    localparam logic [5:0] V_FLUSH = 6'b111100;
    localparam logic [5:0] V_LU    = 6'b001001;
    localparam logic [5:0] V_BA    = 6'b001010;
    localparam logic [5:0] V_RAW   = 6'b001011;
    localparam logic [5:0] V_FRZLU = 6'b000001;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(5)) bus ();
    hazard_ctrl_if #(.REG_AW(5)) bus_nf ();
    state_t dbg_state, dbg_state_nf;

    hazard_ctrl #(.MEM_DELAY(2), .FWD_EN(1), .REG_AW(5)) dut (
        .clk(clk), .nrst(nrst), .bus(bus), .dbg_state(dbg_state)
    );
    hazard_ctrl #(.MEM_DELAY(2), .FWD_EN(0), .REG_AW(5)) dut_nf (
        .clk(clk), .nrst(nrst), .bus(bus_nf), .dbg_state(dbg_state_nf)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [5:0]  s_vec;
    logic [31:0] s_sc;
    state_t      s_st;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input logic v, input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2);
        bus.id_valid = v;  bus.id_opcode = op;  bus.id_rs1 = rs1;  bus.id_rs2 = rs2;
        bus_nf.id_valid = v; bus_nf.id_opcode = op; bus_nf.id_rs1 = rs1; bus_nf.id_rs2 = rs2;
    endtask

    task automatic set_ex(input logic v, input logic [6:0] op, input logic [4:0] rd);
        bus.ex_valid = v;  bus.ex_opcode = op;  bus.ex_rd = rd;
        bus_nf.ex_valid = v; bus_nf.ex_opcode = op; bus_nf.ex_rd = rd;
    endtask

    task automatic set_mem(input logic v, input logic [6:0] op, input logic [4:0] rd);
        bus.mem_valid = v;  bus.mem_opcode = op;  bus.mem_rd = rd;
        bus_nf.mem_valid = v; bus_nf.mem_opcode = op; bus_nf.mem_rd = rd;
    endtask

    task automatic set_ctl(input logic flush, input logic ext);
        bus.flush_i = flush;  bus.ext_stall = ext;
        bus_nf.flush_i = flush; bus_nf.ext_stall = ext;
    endtask

    task automatic idle();
        set_id(1'b0, 7'd0, 5'd0, 5'd0);
        set_ex(1'b0, 7'd0, 5'd0);
        set_mem(1'b0, 7'd0, 5'd0);
        set_ctl(1'b0, 1'b0);
    endtask

    task automatic sample(input bit nf);
        if (nf) begin
            s_vec = {bus_nf.pc_en, bus_nf.fd_en, bus_nf.de_bubble, bus_nf.fd_flush, bus_nf.hazard_type};
            s_sc  = bus_nf.stall_cycles;
            s_st  = dbg_state_nf;
        end else begin
            s_vec = {bus.pc_en, bus.fd_en, bus.de_bubble, bus.fd_flush, bus.hazard_type};
            s_sc  = bus.stall_cycles;
            s_st  = dbg_state;
        end
    endtask

    task automatic do_reset();
        idle();
        nrst = 1'b0;
        step();
        step();
        nrst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle();
        nrst = 1'b0;
        #1 sample(0);
        n_checks++; if (s_vec !== V_ZERO) $display("FAIL rst_outs_async: got %b want %b", s_vec, V_ZERO); else n_pass++;
        step();
        #1 sample(0);
        n_checks++; if (s_vec !== V_ZERO) $display("FAIL rst_outs: got %b want %b", s_vec, V_ZERO); else n_pass++;
        n_checks++; if (s_sc !== 32'd0) $display("FAIL rst_cnt: got %0d want 0", s_sc); else n_pass++;
        n_checks++; if (s_st !== ST_RESET) $display("FAIL rst_state: got %0d want %0d", s_st, ST_RESET); else n_pass++;
        step();
        nrst = 1'b1;
        #1 sample(0);
        n_checks++; if (s_vec !== V_ZERO) $display("FAIL rst_release_outs: got %b want %b", s_vec, V_ZERO); else n_pass++;
        step();
        #1 sample(0);
        n_checks++; if (s_vec !== V_RUN) $display("FAIL rst_run_outs: got %b want %b", s_vec, V_RUN); else n_pass++;
        n_checks++; if (s_st !== ST_RUN) $display("FAIL rst_run_state: got %0d want %0d", s_st, ST_RUN); else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        set_ex(1'b1, OPC_LOAD, 5'd5);
        set_id(1'b1, OPC_OP, 5'd5, 5'd1);
        for (int i = 0; i < 3; i++) begin
            #1 sample(0);
            n_checks++; if (s_vec !== V_LU) $display("FAIL lu_stall[%0d]: got %b want %b", i, s_vec, V_LU); else n_pass++;
            step();
        end
        set_ex(1'b0, 7'd0, 5'd0);
        #1 sample(0);
        n_checks++; if (s_vec !== V_RUN) $display("FAIL lu_resume: got %b want %b", s_vec, V_RUN); else n_pass++;
        n_checks++; if (s_st !== ST_RUN) $display("FAIL lu_state: got %0d want %0d", s_st, ST_RUN); else n_pass++;
        n_checks++; if (s_sc !== 32'd3) $display("FAIL lu_count: got %0d want 3", s_sc); else n_pass++;
    endtask

    task automatic test_branch_hazards();
        do_reset();
        set_ex(1'b1, OPC_LOAD, 5'd5);
        set_id(1'b1, OPC_BRANCH, 5'd5, 5'd0);
        for (int i = 0; i < 4; i++) begin
            #1 sample(0);
            n_checks++; if (s_vec !== V_LU) $display("FAIL lb_stall[%0d]: got %b want %b", i, s_vec, V_LU); else n_pass++;
            step();
        end
        set_ex(1'b0, 7'd0, 5'd0);
        #1 sample(0);
        n_checks++; if (s_vec !== V_RUN) $display("FAIL lb_resume: got %b want %b", s_vec, V_RUN); else n_pass++;
        n_checks++; if (s_sc !== 32'd4) $display("FAIL lb_count: got %0d want 4", s_sc); else n_pass++;

        do_reset();
        set_ex(1'b1, OP_ADDI, 5'd7);
        set_id(1'b1, OPC_BRANCH, 5'd7, 5'd2);
        #1 sample(0);
        n_checks++; if (s_vec !== V_BA) $display("FAIL ba_stall: got %b want %b", s_vec, V_BA); else n_pass++;
        step();
        set_ex(1'b0, 7'd0, 5'd0);
        #1 sample(0);
        n_checks++; if (s_vec !== V_RUN) $display("FAIL ba_resume: got %b want %b", s_vec, V_RUN); else n_pass++;
        n_checks++; if (s_st !== ST_RUN) $display("FAIL ba_state: got %0d want %0d", s_st, ST_RUN); else n_pass++;
        n_checks++; if (s_sc !== 32'd1) $display("FAIL ba_count: got %0d want 1", s_sc); else n_pass++;
    endtask

    task automatic test_x0_and_no_fwd();
        do_reset();
        set_ex(1'b1, OPC_LOAD, 5'd0);
        set_id(1'b1, OPC_OP, 5'd0, 5'd0);
        #1 sample(0);
        n_checks++; if (s_vec !== V_RUN) $display("FAIL x0_fwd: got %b want %b", s_vec, V_RUN); else n_pass++;
        sample(1);
        n_checks++; if (s_vec !== V_RUN) $display("FAIL x0_nofwd: got %b want %b", s_vec, V_RUN); else n_pass++;

        do_reset();
        set_ex(1'b1, OPC_OP, 5'd3);
        set_id(1'b1, OPC_OP, 5'd3, 5'd1);
        #1 sample(0);
        n_checks++; if (s_vec !== V_RUN) $display("FAIL raw_fwd_nostall: got %b want %b", s_vec, V_RUN); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            #1 sample(1);
            n_checks++; if (s_vec !== V_RAW) $display("FAIL raw_ex_stall[%0d]: got %b want %b", i, s_vec, V_RAW); else n_pass++;
            step();
        end
        set_ex(1'b0, 7'd0, 5'd0);
        #1 sample(1);
        n_checks++; if (s_vec !== V_RUN) $display("FAIL raw_ex_resume: got %b want %b", s_vec, V_RUN); else n_pass++;
        n_checks++; if (s_sc !== 32'd2) $display("FAIL raw_ex_count: got %0d want 2", s_sc); else n_pass++;

        do_reset();
        set_mem(1'b1, OPC_OP, 5'd3);
        set_id(1'b1, OPC_OP, 5'd3, 5'd1);
        #1 sample(1);
        n_checks++; if (s_vec !== V_RAW) $display("FAIL raw_mem_stall: got %b want %b", s_vec, V_RAW); else n_pass++;
        sample(0);
        n_checks++; if (s_vec !== V_RUN) $display("FAIL raw_mem_fwd: got %b want %b", s_vec, V_RUN); else n_pass++;
        step();
        set_mem(1'b0, 7'd0, 5'd0);
        #1 sample(1);
        n_checks++; if (s_vec !== V_RUN) $display("FAIL raw_mem_resume: got %b want %b", s_vec, V_RUN); else n_pass++;
        n_checks++; if (s_sc !== 32'd1) $display("FAIL raw_mem_count: got %0d want 1", s_sc); else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        set_ex(1'b1, OPC_LOAD, 5'd5);
        set_id(1'b1, OPC_OP, 5'd5, 5'd1);
        #1 sample(0);
        n_checks++; if (s_vec !== V_LU) $display("FAIL fl_detect: got %b want %b", s_vec, V_LU); else n_pass++;
        step();
        set_ctl(1'b1, 1'b0);
        #1 sample(0);
        n_checks++; if (s_vec !== V_FLUSH) $display("FAIL fl_abort: got %b want %b", s_vec, V_FLUSH); else n_pass++;
        step();
        set_ctl(1'b0, 1'b0);
        set_ex(1'b0, 7'd0, 5'd0);
        #1 sample(0);
        n_checks++; if (s_vec !== V_RUN) $display("FAIL fl_resume: got %b want %b", s_vec, V_RUN); else n_pass++;
        n_checks++; if (s_st !== ST_RUN) $display("FAIL fl_state: got %0d want %0d", s_st, ST_RUN); else n_pass++;
        n_checks++; if (s_sc !== 32'd1) $display("FAIL fl_count: got %0d want 1", s_sc); else n_pass++;

        do_reset();
        set_ex(1'b1, OPC_LOAD, 5'd5);
        set_id(1'b1, OPC_OP, 5'd5, 5'd1);
        set_ctl(1'b1, 1'b0);
        #1 sample(0);
        n_checks++; if (s_vec !== V_FLUSH) $display("FAIL fl_run_outs: got %b want %b", s_vec, V_FLUSH); else n_pass++;
        step();
        set_ctl(1'b0, 1'b0);
        set_ex(1'b0, 7'd0, 5'd0);
        #1 sample(0);
        n_checks++; if (s_st !== ST_RUN) $display("FAIL fl_run_state: got %0d want %0d", s_st, ST_RUN); else n_pass++;
        n_checks++; if (s_sc !== 32'd0) $display("FAIL fl_run_count: got %0d want 0", s_sc); else n_pass++;
    endtask

    task automatic test_ext_stall();
        int pc_low;
        do_reset();
        pc_low = 0;
        set_ex(1'b1, OPC_LOAD, 5'd5);
        set_id(1'b1, OPC_OP, 5'd5, 5'd1);
        set_ctl(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1 sample(0);
            if (s_vec[5] == 1'b0) pc_low++;
            n_checks++; if (s_vec !== V_ZERO) $display("FAIL ext_freeze[%0d]: got %b want %b", i, s_vec, V_ZERO); else n_pass++;
            step();
        end
        set_ctl(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 sample(0);
            if (s_vec[5] == 1'b0) pc_low++;
            n_checks++; if (s_vec !== V_LU) $display("FAIL ext_stall[%0d]: got %b want %b", i, s_vec, V_LU); else n_pass++;
            step();
        end
        set_ex(1'b0, 7'd0, 5'd0);
        #1 sample(0);
        n_checks++; if (s_vec !== V_RUN) $display("FAIL ext_resume: got %b want %b", s_vec, V_RUN); else n_pass++;
        n_checks++; if (pc_low !== 8) $display("FAIL ext_pc_low: got %0d want 8", pc_low); else n_pass++;
        n_checks++; if (s_sc !== 32'd3) $display("FAIL ext_count: got %0d want 3", s_sc); else n_pass++;

        do_reset();
        set_ex(1'b1, OPC_LOAD, 5'd5);
        set_id(1'b1, OPC_OP, 5'd5, 5'd1);
        step();
        set_ctl(1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            #1 sample(0);
            n_checks++; if (s_vec !== V_FRZLU) $display("FAIL ext_mid[%0d]: got %b want %b", i, s_vec, V_FRZLU); else n_pass++;
            step();
        end
        set_ctl(1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1 sample(0);
            n_checks++; if (s_vec !== V_LU) $display("FAIL ext_mid_stall[%0d]: got %b want %b", i, s_vec, V_LU); else n_pass++;
            step();
        end
        set_ex(1'b0, 7'd0, 5'd0);
        #1 sample(0);
        n_checks++; if (s_vec !== V_RUN) $display("FAIL ext_mid_resume: got %b want %b", s_vec, V_RUN); else n_pass++;
        n_checks++; if (s_sc !== 32'd3) $display("FAIL ext_mid_count: got %0d want 3", s_sc); else n_pass++;

        do_reset();
        set_ctl(1'b1, 1'b1);
        #1 sample(0);
        n_checks++; if (s_vec !== V_ZERO) $display("FAIL ext_masks_flush: got %b want %b", s_vec, V_ZERO); else n_pass++;
        step();
        set_ctl(1'b0, 1'b0);
        #1 sample(0);
        n_checks++; if (s_vec !== V_RUN) $display("FAIL ext_flush_after: got %b want %b", s_vec, V_RUN); else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_ex(1'b1, OPC_LOAD, 5'd5);
        set_id(1'b1, OPC_OP, 5'd5, 5'd1);
        step();
        nrst = 1'b0;
        #1 sample(0);
        n_checks++; if (s_vec !== V_ZERO) $display("FAIL rms_outs: got %b want %b", s_vec, V_ZERO); else n_pass++;
        step();
        #1 sample(0);
        n_checks++; if (s_st !== ST_RESET) $display("FAIL rms_state: got %0d want %0d", s_st, ST_RESET); else n_pass++;
        n_checks++; if (s_sc !== 32'd0) $display("FAIL rms_count: got %0d want 0", s_sc); else n_pass++;
        set_ex(1'b0, 7'd0, 5'd0);
        nrst = 1'b1;
        step();
        #1 sample(0);
        n_checks++; if (s_vec !== V_RUN) $display("FAIL rms_resume: got %b want %b", s_vec, V_RUN); else n_pass++;
        step();
        #1 sample(0);
        n_checks++; if (s_vec !== V_RUN) $display("FAIL rms_no_residual: got %b want %b", s_vec, V_RUN); else n_pass++;
        n_checks++; if (s_sc !== 32'd0) $display("FAIL rms_count_after: got %0d want 0", s_sc); else n_pass++;
    endtask

    initial begin
        nrst = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_branch_hazards();
        test_x0_and_no_fwd();
        test_flush();
        test_ext_stall();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
